// File: rtl/cxapbasyncbridge_pkg.sv
// rtl/cxapbasyncbridge_pkg.sv - shared types and payload layout for the async APB bridge
//
// Contents:
//   state_t          slave-side handshake FSM encoding (IDLE=0, REQ=1, RESP=2, DRAIN=3)
//   fwd_width()      forward payload width {paddr,pwdata,pstrb,pprot,pwrite}
//   rev_width()      reverse payload width {prdata,pslverr}
//   FWD_*_LSB        bit offsets of each field inside the forward payload
package cxapbasyncbridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Forward payload, LSB first: pwrite, pprot[2:0], pstrb, pwdata, paddr.
  localparam int FWD_PWRITE_LSB = 0;
  localparam int FWD_PPROT_LSB  = 1;
  localparam int FWD_PSTRB_LSB  = 4;

  function automatic int fwd_width(input int addr_w, input int data_w);
    return addr_w + data_w + (data_w / 8) + 3 + 1;
  endfunction

  function automatic int rev_width(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int fwd_pwdata_lsb(input int data_w);
    return FWD_PSTRB_LSB + (data_w / 8);
  endfunction

  function automatic int fwd_paddr_lsb(input int data_w);
    return FWD_PSTRB_LSB + (data_w / 8) + data_w;
  endfunction

endpackage

// File: rtl/cxapbasyncbridge_sync_nstage.sv
// rtl/cxapbasyncbridge_sync_nstage.sv - reset-to-0 N-flop synchroniser
//
// Ports:
//   pclks     in   destination clock
//   presetsn  in   asynchronous active-low reset, clears every stage
//   d_async   in   signal from the foreign clock domain
//   q_sync    out  synchronised copy, STAGES destination clocks late
module cxapbasyncbridge_sync_nstage #(
  parameter int STAGES = 2
) (
  input  logic pclks,
  input  logic presetsn,
  input  logic d_async,
  output logic q_sync
);

  logic [STAGES-1:0] sync_q;

  // Free-running on pclks (not clock-enabled) so metastability resolution
  // time is one full clock per stage regardless of the APB enable pattern.
  always_ff @(posedge pclks or negedge presetsn) begin
    if (!presetsn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_async};
    end
  end

  assign q_sync = sync_q[STAGES-1];

endmodule

// File: rtl/cxapbasyncbridge_slave_domain_param.sv
// rtl/cxapbasyncbridge_slave_domain_param.sv - APB slave-side half of the async APB bridge
//
// Optional feature macro: CXAPBASYNCBRIDGE_TIMEOUT_EN (response timeout + timeout_irq).
//
// Ports:
//   pclks, presetsn, pclkens        APB clock, async active-low reset, clock enable
//   paddrs/pwdatas/pstrbs/pprots/
//   pwrites/psels/penables          APB4 request from the bus
//   prdatas/pslverrs/preadys        APB response to the bus
//   apbm_req_async                  registered 4-phase request to the master domain
//   apbm_ack_async                  4-phase acknowledge from the master domain
//   apbm_fwd_data_async             registered {paddr,pwdata,pstrb,pprot,pwrite}
//   apbm_rev_data_async             {prdata,pslverr}, stable while ack is high
//   timeout_irq                     one-cycle pulse when a transfer times out
module cxapbasyncbridge_slave_domain_param
  import cxapbasyncbridge_pkg::*;
#(
  parameter int  ADDR_W         = 32,
  parameter int  DATA_W         = 32,
  parameter int  SYNC_STAGES    = 2,
  parameter int  TIMEOUT_CYCLES = 256,
  localparam int STRB_W         = DATA_W / 8,
  localparam int FWD_W          = fwd_width(ADDR_W, DATA_W),
  localparam int REV_W          = rev_width(DATA_W)
) (
  input  logic              pclks,
  input  logic              presetsn,
  input  logic              pclkens,
  input  logic [ADDR_W-1:0] paddrs,
  input  logic [DATA_W-1:0] pwdatas,
  input  logic [STRB_W-1:0] pstrbs,
  input  logic [2:0]        pprots,
  input  logic              pwrites,
  input  logic              psels,
  input  logic              penables,
  output logic [DATA_W-1:0] prdatas,
  output logic              pslverrs,
  output logic              preadys,
  output logic              apbm_req_async,
  input  logic              apbm_ack_async,
  output logic [FWD_W-1:0]  apbm_fwd_data_async,
  input  logic [REV_W-1:0]  apbm_rev_data_async,
  output logic              timeout_irq
);

  localparam int PWDATA_LSB = fwd_pwdata_lsb(DATA_W);
  localparam int PADDR_LSB  = fwd_paddr_lsb(DATA_W);

  state_t            state_q, state_nxt;
  logic              ack_sync;
  logic              req_nxt;
  logic [FWD_W-1:0]  fwd_nxt;
  logic              rdy_nxt;
  logic [DATA_W-1:0] prdata_nxt;
  logic              err_nxt;
  logic              late_ack;

  cxapbasyncbridge_sync_nstage #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .pclks    (pclks),
    .presetsn (presetsn),
    .d_async  (apbm_ack_async),
    .q_sync   (ack_sync)
  );

`ifdef CXAPBASYNCBRIDGE_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt_q, tmo_cnt_nxt;
  logic        late_ack_q, late_nxt;
  logic        irq_nxt;

  assign late_ack = late_ack_q;

  always_ff @(posedge pclks or negedge presetsn) begin
    if (!presetsn) begin
      tmo_cnt_q   <= '0;
      late_ack_q  <= 1'b0;
      timeout_irq <= 1'b0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_nxt;
      late_ack_q  <= late_nxt;
      timeout_irq <= irq_nxt;
    end
  end
`else
  assign late_ack    = 1'b0;
  assign timeout_irq = 1'b0;

  // Range marker: an out-of-range TIMEOUT_CYCLES shows up as this scope.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_timeout_cycles_out_of_range
  end
`endif

  always_ff @(posedge pclks or negedge presetsn) begin
    if (!presetsn) begin
      state_q             <= ST_IDLE;
      apbm_req_async      <= 1'b0;
      apbm_fwd_data_async <= '0;
      preadys             <= 1'b0;
      prdatas             <= '0;
      pslverrs            <= 1'b0;
    end else begin
      state_q             <= state_nxt;
      apbm_req_async      <= req_nxt;
      apbm_fwd_data_async <= fwd_nxt;
      preadys             <= rdy_nxt;
      prdatas             <= prdata_nxt;
      pslverrs            <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    req_nxt    = apbm_req_async;
    fwd_nxt    = apbm_fwd_data_async;
    rdy_nxt    = preadys;
    prdata_nxt = prdatas;
    err_nxt    = pslverrs;
`ifdef CXAPBASYNCBRIDGE_TIMEOUT_EN
    tmo_cnt_nxt = tmo_cnt_q;
    late_nxt    = late_ack_q;
    irq_nxt     = 1'b0;
`endif

    if (pclkens) begin
      case (state_q)
        ST_IDLE: begin
          // A still-high ack belongs to the previous handshake; wait for it
          // to drop before raising a new req.
          if (psels && penables && !preadys && !ack_sync) begin
            fwd_nxt[FWD_PWRITE_LSB]          = pwrites;
            fwd_nxt[FWD_PPROT_LSB +: 3]      = pprots;
            fwd_nxt[FWD_PSTRB_LSB +: STRB_W] = pstrbs;
            fwd_nxt[PWDATA_LSB +: DATA_W]    = pwdatas;
            fwd_nxt[PADDR_LSB +: ADDR_W]     = paddrs;
            req_nxt   = 1'b1;
            state_nxt = ST_REQ;
`ifdef CXAPBASYNCBRIDGE_TIMEOUT_EN
            tmo_cnt_nxt = '0;
`endif
          end
        end

        ST_REQ: begin
          if (ack_sync) begin
            prdata_nxt = apbm_rev_data_async[REV_W-1:1];
            err_nxt    = apbm_rev_data_async[0];
            req_nxt    = 1'b0;
            rdy_nxt    = 1'b1;
            state_nxt  = ST_RESP;
          end
`ifdef CXAPBASYNCBRIDGE_TIMEOUT_EN
          // Answer the bus with an error but keep req high: the master
          // domain may still be executing the transfer, so the handshake
          // has to be finished in DRAIN before anything new is launched.
          else if (tmo_cnt_q == TMO_LAST) begin
            prdata_nxt = '0;
            err_nxt    = 1'b1;
            rdy_nxt    = 1'b1;
            irq_nxt    = 1'b1;
            late_nxt   = 1'b1;
            state_nxt  = ST_RESP;
          end else begin
            tmo_cnt_nxt = tmo_cnt_q + 16'd1;
          end
`endif
        end

        ST_RESP: begin
          rdy_nxt = 1'b0;
          if (late_ack || ack_sync) begin
            state_nxt = ST_DRAIN;
          end else begin
            state_nxt = ST_IDLE;
          end
        end

        ST_DRAIN: begin
          if (late_ack) begin
            // Late ack: close the req phase; its rev data is ignored.
            if (ack_sync) begin
              req_nxt = 1'b0;
`ifdef CXAPBASYNCBRIDGE_TIMEOUT_EN
              late_nxt = 1'b0;
`endif
            end
          end else if (!ack_sync) begin
            state_nxt = ST_IDLE;
          end
        end

        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule
